nand_gate_checker: RTL and testbench



---
 rtl/nand_gate_checker.sv | 193 +++++++++++++++++++
 tb/tb_nand_gate_checker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_gate_checker.sv
// ---------------------------------------------------------------------------
// nand_gate_checker
//
// Stimulus/response sequencer wrapped around a two-input NAND stage. It
// drives the stage's operands through the four combinations 00, 01, 10, 11
// (one full sweep per pass), holds each combination for SETTLE_CYCLES cycles,
// then spends one SAMPLE cycle and compares the returned y against ~(a & b)
// on the edge that ends it. Mismatches are counted (saturating) and recorded
// per combination in fail_mask.
//
// Parameters:
//   SETTLE_CYCLES  cycles operands are held before sampling (>= 1)
//   NUM_PASSES     full 4-vector sweeps per run (>= 1)
//   CNT_W          width of the saturating error counter
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      level; starts a run when in IDLE or DONE
//   y          NAND stage output under check
//   a, b       registered operands to the NAND stage
//   busy       high while a run is in progress
//   done       high from run completion until the next accepted start/reset
//   pass       valid while done; 1 iff err_cnt == 0
//   err_cnt    saturating count of mismatches
//   fail_mask  bit i set if combination {a,b} == i mismatched at least once
// ---------------------------------------------------------------------------
module nand_gate_checker #(
    parameter int SETTLE_CYCLES = 2,
    parameter int NUM_PASSES    = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y,
    output logic             a,
    output logic             b,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       fail_mask
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Counter widths never drop below one bit so degenerate parameter values
    // (SETTLE_CYCLES=1, NUM_PASSES=1) still give legal vectors.
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;

    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [PW-1:0]    PASS_LAST   = PW'(NUM_PASSES - 1);
    localparam logic [SW-1:0]    SETTLE_ONE  = SW'(1);
    localparam logic [PW-1:0]    PASS_ONE    = PW'(1);
    localparam logic [CNT_W-1:0] ERR_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] ERR_MAX     = '1;

    state_t            state;
    state_t            state_next;
    logic [1:0]        idx;
    logic [1:0]        idx_next;
    logic [PW-1:0]     pass_idx;
    logic [PW-1:0]     pass_idx_next;
    logic [SW-1:0]     settle_cnt;
    logic [SW-1:0]     settle_next;
    logic [CNT_W-1:0]  err_next;
    logic [3:0]        mask_next;
    logic              done_next;
    logic              pass_next;
    logic              mismatch;
    logic              a_next;
    logic              b_next;
    logic              busy_next;

    // State register together with the datapath registers it owns. Every
    // output is a flop, so the NAND stage sees glitch-free operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            pass_idx   <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            fail_mask  <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            pass_idx   <= pass_idx_next;
            settle_cnt <= settle_next;
            err_cnt    <= err_next;
            fail_mask  <= mask_next;
            done       <= done_next;
            pass       <= pass_next;
            a          <= a_next;
            b          <= b_next;
            busy       <= busy_next;
        end
    end

    // Next-state and datapath update. The comparison in SAMPLE uses the
    // registered a/b, which have been stable for SETTLE_CYCLES+1 cycles by
    // then. The verdict for pass is taken from err_next so that a mismatch on
    // the very last vector is already reflected when done rises.
    always_comb begin
        state_next    = state;
        idx_next      = idx;
        pass_idx_next = pass_idx;
        settle_next   = settle_cnt;
        err_next      = err_cnt;
        mask_next     = fail_mask;
        done_next     = done;
        pass_next     = pass;
        mismatch      = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_next    = ST_DRIVE;
                    idx_next      = 2'd0;
                    pass_idx_next = '0;
                    settle_next   = '0;
                    err_next      = '0;
                    mask_next     = 4'b0000;
                    done_next     = 1'b0;
                    pass_next     = 1'b0;
                end
            end

            ST_DRIVE: begin
                if (settle_cnt == SETTLE_LAST) begin
                    settle_next = '0;
                    state_next  = ST_SAMPLE;
                end else begin
                    settle_next = settle_cnt + SETTLE_ONE;
                end
            end

            ST_SAMPLE: begin
                mismatch = (y != ~(a & b));
                if (mismatch) begin
                    if (err_cnt != ERR_MAX) begin
                        err_next = err_cnt + ERR_ONE;
                    end
                    mask_next[idx] = 1'b1;
                end

                if (idx != 2'd3) begin
                    idx_next   = idx + 2'd1;
                    state_next = ST_DRIVE;
                end else if (pass_idx < PASS_LAST) begin
                    pass_idx_next = pass_idx + PASS_ONE;
                    idx_next      = 2'd0;
                    state_next    = ST_DRIVE;
                end else begin
                    state_next = ST_DONE;
                    done_next  = 1'b1;
                    pass_next  = (err_next == '0);
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode. It looks at the upcoming state and vector index so the
    // registered a/b/busy line up with the state they belong to: the cycle
    // after start is accepted already shows {a,b}=00 with busy high.
    always_comb begin
        a_next    = 1'b0;
        b_next    = 1'b0;
        busy_next = 1'b0;
        if ((state_next == ST_DRIVE) || (state_next == ST_SAMPLE)) begin
            a_next    = idx_next[1];
            b_next    = idx_next[0];
            busy_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_nand_gate_checker.sv
// ---------------------------------------------------------------------------
// tb_nand_gate_checker
//
// Three checker instances share one clock and reset:
//   u0  defaults (SETTLE_CYCLES=2, NUM_PASSES=1, CNT_W=8)
//   u1  NUM_PASSES=3
//   u2  NUM_PASSES=2, CNT_W=2 (saturation)
// Each instance closes the loop through a behavioural stage whose function
// (correct NAND, stuck-at-1, stuck-at-0, AND) is selected per run.
// Expected run results are queued when a run is started; a monitor pops them
// whenever an instance raises done and compares verdict, counters, busy
// length and (for u0) the sequence of operands presented while busy.
// ---------------------------------------------------------------------------
module tb_nand_gate_checker;

    localparam int MODE_NAND   = 0;
    localparam int MODE_STUCK1 = 1;
    localparam int MODE_STUCK0 = 2;
    localparam int MODE_AND    = 3;

    // {a,b} per busy cycle for one default sweep:
    // 00 00 00 01 01 01 10 10 10 11 11 11
    localparam int TRACE_DEFAULT = 'h015ABF;

    typedef struct {
        int   err;
        int   mask;
        int   pass;
        int   busy_len;
        logic check_trace;
        int   trace;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start1, start2;
    int         mode0, mode1, mode2;
    logic       y0, y1, y2;

    logic       a0, b0, busy0, done0, pass0;
    logic [7:0] err0;
    logic [3:0] mask0;
    logic       a1, b1, busy1, done1, pass1;
    logic [7:0] err1;
    logic [3:0] mask1;
    logic       a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [3:0] mask2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int   checks = 0;
    int   passed = 0;
    int   busy_cnt[3];
    int   trace[3];
    logic busy_prev[3];
    logic done_prev[3];

    always #5 clk = ~clk;

    // Behavioural stage under check.
    function automatic logic stageModel(input int mode, input logic a, input logic b);
        case (mode)
            MODE_STUCK1: return 1'b1;
            MODE_STUCK0: return 1'b0;
            MODE_AND:    return a & b;
            default:     return ~(a & b);
        endcase
    endfunction

    assign y0 = stageModel(mode0, a0, b0);
    assign y1 = stageModel(mode1, a1, b1);
    assign y2 = stageModel(mode2, a2, b2);

    nand_gate_checker u0 (
        .clk(clk), .rst(rst), .start(start0), .y(y0),
        .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(err0), .fail_mask(mask0)
    );

    nand_gate_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(3), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1),
        .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .fail_mask(mask1)
    );

    nand_gate_checker #(.SETTLE_CYCLES(2), .NUM_PASSES(2), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .start(start2), .y(y2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .fail_mask(mask2)
    );

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input int got, input int exp);
        checks++;
        if (got == exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, got, got, exp, exp);
        end
    endtask

    function automatic exp_t mkExp(input int err, input int mask, input int pass,
                                   input int busy_len, input logic check_trace,
                                   input int tr);
        exp_t e;
        e.err         = err;
        e.mask        = mask;
        e.pass        = pass;
        e.busy_len    = busy_len;
        e.check_trace = check_trace;
        e.trace       = tr;
        return e;
    endfunction

    // Per-instance monitor step: measures the busy window, records the operand
    // trace, and on a rising done pops and compares the queued expectation.
    task automatic monitorStep(input int id, input logic busy, input logic done,
                               input logic pass, input int err, input int mask,
                               input int ab);
        exp_t e;
        int   sz;
        if (busy && !busy_prev[id]) begin
            busy_cnt[id] = 0;
            trace[id]    = 0;
        end
        if (busy) begin
            busy_cnt[id] = busy_cnt[id] + 1;
            trace[id]    = (trace[id] << 2) | ab;
        end
        if (done && !done_prev[id]) begin
            case (id)
                0:       sz = q0.size();
                1:       sz = q1.size();
                default: sz = q2.size();
            endcase
            if (sz == 0) begin
                checkOutput($sformatf("u%0d unexpected done", id), 1, 0);
            end else begin
                case (id)
                    0:       e = q0.pop_front();
                    1:       e = q1.pop_front();
                    default: e = q2.pop_front();
                endcase
                checkOutput($sformatf("u%0d err_cnt", id), err, e.err);
                checkOutput($sformatf("u%0d fail_mask", id), mask, e.mask);
                checkOutput($sformatf("u%0d pass", id), int'(pass), e.pass);
                checkOutput($sformatf("u%0d busy length", id), busy_cnt[id], e.busy_len);
                if (e.check_trace) begin
                    checkOutput($sformatf("u%0d operand trace", id), trace[id], e.trace);
                end
            end
        end
        busy_prev[id] = busy;
        done_prev[id] = done;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            busy_cnt[i]  = 0;
            trace[i]     = 0;
            busy_prev[i] = 1'b0;
            done_prev[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            monitorStep(0, busy0, done0, pass0, int'(err0), int'(mask0), int'({a0, b0}));
            monitorStep(1, busy1, done1, pass1, int'(err1), int'(mask1), int'({a1, b1}));
            monitorStep(2, busy2, done2, pass2, int'(err2), int'(mask2), int'({a2, b2}));
        end else begin
            for (int i = 0; i < 3; i++) begin
                busy_prev[i] = 1'b0;
                done_prev[i] = 1'b0;
            end
        end
    end

    // Pulse start on one instance for a single edge. Returns at the falling
    // edge of cycle 1 of the run.
    task automatic applyStimulus(input int id);
        @(negedge clk);
        case (id)
            0:       start0 = 1'b1;
            1:       start1 = 1'b1;
            default: start2 = 1'b1;
        endcase
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic waitDone(input int id, input int limit);
        logic d;
        int   n;
        d = 1'b0;
        n = 0;
        while (!d && (n < limit)) begin
            @(negedge clk);
            n++;
            case (id)
                0:       d = done0;
                1:       d = done1;
                default: d = done2;
            endcase
        end
        if (!d) begin
            checkOutput($sformatf("u%0d done timeout", id), 0, 1);
        end
    endtask

    task automatic checkU0Zero(input string tag);
        checkOutput({tag, " a"}, int'(a0), 0);
        checkOutput({tag, " b"}, int'(b0), 0);
        checkOutput({tag, " busy"}, int'(busy0), 0);
        checkOutput({tag, " done"}, int'(done0), 0);
        checkOutput({tag, " pass"}, int'(pass0), 0);
        checkOutput({tag, " err_cnt"}, int'(err0), 0);
        checkOutput({tag, " fail_mask"}, int'(mask0), 0);
    endtask

    initial begin
        rst    = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        mode0  = MODE_NAND;
        mode1  = MODE_NAND;
        mode2  = MODE_NAND;

        // Reset state
        repeat (3) @(negedge clk);
        checkU0Zero("reset");
        checkOutput("reset u1 busy", int'(busy1), 0);
        checkOutput("reset u2 err_cnt", int'(err2), 0);
        rst = 1'b0;

        // Correct stage, defaults
        q0.push_back(mkExp(0, 4'b0000, 1, 12, 1'b1, TRACE_DEFAULT));
        applyStimulus(0);
        checkOutput("cycle1 busy", int'(busy0), 1);
        checkOutput("cycle1 ab", int'({a0, b0}), 0);
        waitDone(0, 40);

        // Stuck-at-1, three passes: only 11 fails, once per pass
        mode1 = MODE_STUCK1;
        q1.push_back(mkExp(3, 4'b1000, 0, 36, 1'b0, 0));
        applyStimulus(1);
        waitDone(1, 100);

        // Stuck-at-0 then AND on the default instance
        mode0 = MODE_STUCK0;
        q0.push_back(mkExp(3, 4'b0111, 0, 12, 1'b1, TRACE_DEFAULT));
        applyStimulus(0);
        waitDone(0, 40);
        mode0 = MODE_AND;
        q0.push_back(mkExp(4, 4'b1111, 0, 12, 1'b1, TRACE_DEFAULT));
        applyStimulus(0);
        waitDone(0, 40);

        // Saturation: six mismatches into a 2-bit counter
        mode2 = MODE_STUCK0;
        q2.push_back(mkExp(3, 4'b0111, 0, 24, 1'b0, 0));
        applyStimulus(2);
        waitDone(2, 100);

        // Reset at cycle 5 of a run aborts it without done
        mode0 = MODE_NAND;
        applyStimulus(0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkU0Zero("midrun reset");
        repeat (20) @(negedge clk);
        checkOutput("no done after abort", int'(done0), 0);

        // start while busy is ignored; done still at cycle 13
        mode0 = MODE_STUCK0;
        q0.push_back(mkExp(3, 4'b0111, 0, 12, 1'b1, TRACE_DEFAULT));
        applyStimulus(0);
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (7) @(negedge clk);
        checkOutput("cycle12 done", int'(done0), 0);
        checkOutput("cycle12 busy", int'(busy0), 1);
        @(negedge clk);
        checkOutput("cycle13 done", int'(done0), 1);
        checkOutput("cycle13 busy", int'(busy0), 0);

        // Restart from DONE clears results and starts again at 00
        mode0 = MODE_NAND;
        q0.push_back(mkExp(0, 4'b0000, 1, 12, 1'b1, TRACE_DEFAULT));
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        checkOutput("restart done", int'(done0), 0);
        checkOutput("restart err_cnt", int'(err0), 0);
        checkOutput("restart fail_mask", int'(mask0), 0);
        checkOutput("restart ab", int'({a0, b0}), 0);
        checkOutput("restart busy", int'(busy0), 1);
        waitDone(0, 40);

        @(negedge clk);
        checkOutput("u0 queue drained", q0.size(), 0);
        checkOutput("u1 queue drained", q1.size(), 0);
        checkOutput("u2 queue drained", q2.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
